uart_tx_fifo: RTL

//   Buffered UART transmitter, 8N1, LSB first. Accepts bytes from user logic over
//   a valid/ready handshake into an internal FIFO. Serialises them onto uart_tx

---
 rtl/uart_tx_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 LSB-first UART transmitter fed by a FIFO; frames go out back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             uart_tx,
  output logic             tx_busy,
  output logic [FIFO_AW:0] fifo_count
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT-1);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [1:0]         r_state;
  logic [BW-1:0]      r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shreg;
  logic               r_tx;
  logic               w_push, w_pop, w_baud_done;
  assign tx_ready    = r_count != FULL;
  assign w_push      = tx_valid && tx_ready;
  assign w_baud_done = r_baud == BAUD_MAX;
  // The head is popped on entry to START, either from IDLE or straight out of STOP.
  assign w_pop       = (r_count != '0) && (r_state == S_IDLE || (r_state == S_STOP && w_baud_done));
  assign uart_tx     = r_tx;
  assign tx_busy     = r_state != S_IDLE;
  assign fifo_count  = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= (w_push && !w_pop) ? r_count + ONE : (w_pop && !w_push) ? r_count - ONE : r_count;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_baud <= (r_state == S_IDLE || w_baud_done) ? '0 : r_baud + BW'(1);
      case (r_state)
        S_IDLE:
          if (w_pop) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_shreg <= r_mem[r_rd_ptr];
          end
        S_START:
          if (w_baud_done) begin
            r_state <= S_DATA;
            r_tx    <= r_shreg[0];
            r_bit   <= '0;
          end
        S_DATA:
          if (w_baud_done) begin
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shreg <= {1'b0, r_shreg[7:1]};
              r_tx    <= r_shreg[1];
              r_bit   <= r_bit + 3'd1;
            end
          end
        default:
          if (w_baud_done) begin
            r_state <= w_pop ? S_START : S_IDLE;
            r_tx    <= !w_pop;
            if (w_pop) r_shreg <= r_mem[r_rd_ptr];
          end
      endcase
    end
endmodule
